// File: rtl/random_range_sampler_pkg.sv
// Shared definitions for the random range sampler: data width, FSM states
// and the FIFO depth legality rule.
package random_range_sampler_pkg;

  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RUN  = 2'd2
  } state_e;

  // FIFO depth must be a power of two in 2..16
  function automatic bit depth_legal(input int unsigned depth);
    return (depth >= 32'd2) && (depth <= 32'd16) && ((depth & (depth - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/random_range_sampler_sample_fifo.sv
// sample_fifo: synchronous first-word-fall-through FIFO, DEPTH x WIDTH,
// with a flush input that empties it in one cycle and beats push/pop.
module sample_fifo
  import random_range_sampler_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full     = (cnt_q == FULL_CNT);
  assign empty    = (cnt_q == '0);
  // Head is presented combinationally; zero while empty so idle output is clean
  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

  // Next pointer/occupancy; flush wins over any push or pop
  always_comb begin
    do_push  = push && !full && !flush;
    do_pop   = pop && !empty && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + (AW+1)'(1);
        2'b01:   cnt_d = cnt_q - (AW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage write; contents need no reset since occupancy gates the read
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/random_range_sampler.sv
// random_range_sampler: maps a free-running 16-bit random word stream onto
// the inclusive range [lo, hi] by mask-and-reject sampling, buffering
// accepted values in a sample_fifo behind a valid/ready output.
// Optional macro RANDOM_RANGE_SAMPLER_STATS_EN adds stat_accept/stat_reject.
module random_range_sampler
  import random_range_sampler_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_load,
  input  logic [DATA_W-1:0] cfg_lo,
  input  logic [DATA_W-1:0] cfg_hi,
  input  logic [DATA_W-1:0] rand_in,
  input  logic              rand_valid,
  output logic              rand_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              cfg_busy,
  output logic              cfg_err
`ifdef RANDOM_RANGE_SAMPLER_STATS_EN
  ,
  output logic [31:0]       stat_accept,
  output logic [31:0]       stat_reject
`endif
);

  if (!depth_legal(DEPTH)) begin : g_depth_check
    $error("random_range_sampler: DEPTH must be a power of two in 2..16");
  end

  state_e            state_q, state_d;
  logic [DATA_W-1:0] mask_q, mask_d;
  logic [DATA_W-1:0] span_q, span_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

  logic [DATA_W-1:0] cand;
  logic [DATA_W-1:0] push_data;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic              consume;

  assign rand_ready = (state_q == RUN) && !fifo_full;
  assign out_valid  = !fifo_empty;
  assign cfg_busy   = busy_q;
  assign cfg_err    = err_q;
  assign fifo_pop   = out_valid && out_ready;
  assign consume    = rand_valid && rand_ready && !cfg_load;
  assign cand       = rand_in & mask_q;
  assign push_data  = lo_q + cand;

  // Next-state: cfg_load restarts from any state; CALC grows the mask one bit
  // per cycle until it covers span_m1; RUN accepts candidates within span.
  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    span_d    = span_q;
    lo_d      = lo_q;
    err_d     = err_q;
    fifo_push = 1'b0;
    if (cfg_load) begin
      mask_d  = '0;
      lo_d    = cfg_lo;
      span_d  = cfg_hi - cfg_lo;
      err_d   = (cfg_lo > cfg_hi);
      state_d = (cfg_lo > cfg_hi) ? IDLE : CALC;
    end else begin
      case (state_q)
        CALC: begin
          if (mask_q < span_q) mask_d = {mask_q[DATA_W-2:0], 1'b1};
          else                 state_d = RUN;
        end
        RUN: begin
          if (consume && (cand <= span_q)) fifo_push = 1'b1;
        end
        default: state_d = state_q;
      endcase
    end
    busy_d = (state_d == CALC);
  end

  // FSM and configuration registers with registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mask_q  <= '0;
      span_q  <= '0;
      lo_q    <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      span_q  <= span_d;
      lo_q    <= lo_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  sample_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (cfg_load),
    .push      (fifo_push),
    .push_data (push_data),
    .pop       (fifo_pop),
    .pop_data  (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef RANDOM_RANGE_SAMPLER_STATS_EN
  logic [31:0] accept_q, accept_d;
  logic [31:0] reject_q, reject_d;

  assign stat_accept = accept_q;
  assign stat_reject = reject_q;

  // Saturating counts of consumed words, cleared by cfg_load
  always_comb begin
    accept_d = accept_q;
    reject_d = reject_q;
    if (cfg_load) begin
      accept_d = '0;
      reject_d = '0;
    end else if (consume) begin
      if (cand <= span_q) begin
        if (accept_q != '1) accept_d = accept_q + 32'd1;
      end else begin
        if (reject_q != '1) reject_d = reject_q + 32'd1;
      end
    end
  end

  // Statistics registers
  always_ff @(posedge clk) begin
    if (reset) begin
      accept_q <= '0;
      reject_q <= '0;
    end else begin
      accept_q <= accept_d;
      reject_q <= reject_d;
    end
  end
`endif

endmodule

// File: tb/tb_random_range_sampler.sv
// Self-checking bench for random_range_sampler. A reference model predicts
// handshake/status behaviour and pushes expected output values into a queue;
// a separate monitor compares and pops whenever the DUT presents data.
module tb_random_range_sampler;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_load = 1'b0;
  logic [15:0] cfg_lo = '0;
  logic [15:0] cfg_hi = '0;
  logic [15:0] rand_in = '0;
  logic        rand_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        rand_ready, out_valid, cfg_busy, cfg_err;
  logic [15:0] out_data;
`ifdef RANDOM_RANGE_SAMPLER_STATS_EN
  logic [31:0] stat_accept, stat_reject;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  random_range_sampler #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_load   (cfg_load),
    .cfg_lo     (cfg_lo),
    .cfg_hi     (cfg_hi),
    .rand_in    (rand_in),
    .rand_valid (rand_valid),
    .rand_ready (rand_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .cfg_busy   (cfg_busy),
    .cfg_err    (cfg_err)
`ifdef RANDOM_RANGE_SAMPLER_STATS_EN
    ,
    .stat_accept(stat_accept),
    .stat_reject(stat_reject)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum {M_IDLE, M_CALC, M_RUN} mstate_e;
  mstate_e     m_state = M_IDLE;
  int          m_calc_left = 0;
  logic [15:0] m_lo = '0, m_span = '0, m_mask = '0;
  logic        m_err = 1'b0;
  logic [15:0] exp_q [$];
  longint      m_acc = 0, m_rej = 0;

  // Mask = 2^k - 1 for the smallest k with 2^k > span; setup takes k+1 cycles
  function automatic void range_setup(input logic [15:0] span, output logic [15:0] mask,
                                      output int cycles);
    int k = 0;
    while ((32'd1 << k) <= {16'd0, span}) k++;
    mask   = 16'(((32'd1 << k) - 32'd1));
    cycles = k + 1;
  endfunction

  initial begin
    logic        exp_ready, take;
    logic [15:0] cand;
    forever begin
      @(posedge clk); #3;
      exp_ready = (m_state == M_RUN) && (exp_q.size() < int'(DEPTH));
      check("rand_ready", 32'(rand_ready), 32'(exp_ready));
      check("cfg_busy", 32'(cfg_busy), 32'(m_state == M_CALC));
      check("cfg_err", 32'(cfg_err), 32'(m_err));
`ifdef RANDOM_RANGE_SAMPLER_STATS_EN
      check("stat_accept", stat_accept, 32'(m_acc));
      check("stat_reject", stat_reject, 32'(m_rej));
`endif
      take = exp_ready && rand_valid;
      @(negedge clk); #1;
      if (reset) begin
        m_state = M_IDLE; m_err = 1'b0; m_mask = '0;
        exp_q.delete(); m_acc = 0; m_rej = 0;
      end else if (cfg_load) begin
        exp_q.delete(); m_acc = 0; m_rej = 0;
        m_err = (cfg_lo > cfg_hi);
        if (m_err) m_state = M_IDLE;
        else begin
          m_lo   = cfg_lo;
          m_span = cfg_hi - cfg_lo;
          range_setup(m_span, m_mask, m_calc_left);
          m_state = M_CALC;
        end
      end else if (m_state == M_CALC) begin
        m_calc_left--;
        if (m_calc_left == 0) m_state = M_RUN;
      end else if (m_state == M_RUN && take) begin
        cand = rand_in & m_mask;
        if (cand <= m_span) begin
          exp_q.push_back(m_lo + cand);
          m_acc++;
        end else m_rej++;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      if (out_valid && exp_q.size() != 0) begin
        check("out_data", 32'(out_data), 32'(exp_q[0]));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic v, input logic [15:0] d, input logic rdy);
    @(posedge clk); #1;
    cfg_load = 1'b0; rand_valid = v; rand_in = d; out_ready = rdy;
  endtask

  task automatic load(input logic [15:0] lo, input logic [15:0] hi, input logic rdy);
    @(posedge clk); #1;
    cfg_load = 1'b1; cfg_lo = lo; cfg_hi = hi;
    rand_valid = 1'($urandom); rand_in = 16'($urandom); out_ready = rdy;
  endtask

  task automatic wait_run(input logic rdy);
    for (int i = 0; i < 40 && m_state != M_RUN; i++) cyc(1'b0, 16'd0, rdy);
  endtask

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(1'($urandom), 16'($urandom), 1'($urandom));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset, then no configuration: nothing may be accepted
    repeat (3) cyc(1'b1, 16'($urandom), 1'b1);
    check("reset_out_data", 32'(out_data), 32'd0);
    reset = 1'b0;
    repeat (20) cyc(1'b1, 16'($urandom), 1'b1);
    check("idle_out_data", 32'(out_data), 32'd0);

    // [10,17]: mask 0x7, four setup cycles
    load(16'd10, 16'd17, 1'b1);
    wait_run(1'b1);
    cyc(1'b1, 16'h0003, 1'b1);
    cyc(1'b1, 16'hFFFF, 1'b1);
    cyc(1'b0, 16'h0000, 1'b1);
    rand_cycles(30);

    // [0,4]: mask 0x7, 6 rejected, 4 accepted
    load(16'd0, 16'd4, 1'b1);
    wait_run(1'b1);
    cyc(1'b1, 16'h0006, 1'b1);
    cyc(1'b1, 16'h0004, 1'b1);
    cyc(1'b0, 16'h0000, 1'b1);
    rand_cycles(30);

    // full range with a stalled consumer: FIFO fills, then drains in order
    load(16'd0, 16'hFFFF, 1'b0);
    wait_run(1'b0);
    repeat (8) cyc(1'b1, 16'($urandom), 1'b0);
    repeat (10) cyc(1'b1, 16'($urandom), 1'b1);

    // inverted range flags an error; single-value range afterwards
    load(16'd20, 16'd5, 1'b1);
    repeat (5) cyc(1'b1, 16'($urandom), 1'b1);
    load(16'd7, 16'd7, 1'b1);
    wait_run(1'b1);
    repeat (12) cyc(1'b1, 16'($urandom), 1'($urandom));

    // reload while three entries are queued and the consumer is ready
    load(16'd0, 16'hFFFF, 1'b0);
    wait_run(1'b0);
    repeat (3) cyc(1'b1, 16'($urandom), 1'b0);
    cyc(1'b0, 16'd0, 1'b0);
    load(16'd3, 16'd9, 1'b1);
    repeat (4) cyc(1'b0, 16'd0, 1'b1);

    // random configurations, including reloads mid-stream
    for (int t = 0; t < 20; t++) begin
      logic [15:0] lo, hi;
      lo = 16'($urandom);
      hi = ($urandom_range(0, 4) == 0) ? 16'($urandom) : lo + 16'($urandom_range(0, 3000));
      if (hi < lo && $urandom_range(0, 1) == 1) hi = 16'hFFFF;
      load(lo, hi, 1'($urandom));
      rand_cycles(int'($urandom_range(10, 50)));
    end
    repeat (10) cyc(1'b0, 16'd0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
